// File: rtl/fifo_pkg.sv
// Shared defaults, read-mode encodings and sizing helper for the synchronous FIFO.
// Latency and backpressure: none, this package holds only constants and a function.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  // One extra bit so the counter can represent a completely full FIFO.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// 1W/1R register array with a combinational read port and no reset.
// Latency: a write is visible on rdata the cycle after it; no backpressure, the caller gates we.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, level flags and sticky errors.
// Latency: 1 cycle write-to-visible; a write when full is dropped (overflow) unless a read frees a slot that cycle.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = MODE_REG
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [count_w(DEPTH)-1:0]   count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] mem_rdata, rd_data_q;
  logic              rd_valid_q, overflow_q, underflow_q;
  logic              wr_acc, rd_acc, ovf_set, unf_set;

  // Flags come only from the registered count, never from this cycle's requests.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;

  assign rd_acc  = rd_en && !empty;
  assign wr_acc  = wr_en && (!full || rd_acc);
  assign ovf_set = wr_en && !wr_acc;
  assign unf_set = rd_en && empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);

      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_rdata;

      // A new error in the same cycle as a clear must survive the clear.
      if (ovf_set)      overflow_q <= 1'b1;
      else if (clr_err) overflow_q <= 1'b0;

      if (unf_set)      underflow_q <= 1'b1;
      else if (clr_err) underflow_q <= 1'b0;
    end
  end

  // FWFT masks the unreset memory while empty so rd_data reads as zero.
  assign rd_data   = (FWFT == MODE_FWFT) ? (empty ? '0 : mem_rdata) : rd_data_q;
  assign rd_valid  = (FWFT == MODE_FWFT) ? !empty : rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench: one registered-read and one FWFT instance share random and directed stimulus.
// A queue model predicts occupancy, flags and read order; negedge monitors pop expected words.
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] r_data, f_data;
  logic          r_valid, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic          f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] r_count, f_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_r[$];
  logic [DW-1:0] exp_f[$];
  bit            m_ovf, m_unf;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) dut_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(r_data), .rd_valid(r_valid), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
  );

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(f_data), .rd_valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of one clock edge, driven by the current input values.
  task automatic model_edge();
    bit ra, wa;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    ra = rd_en && (mq.size() > 0);
    wa = wr_en && ((mq.size() < DEPTH) || ra);
    if (ra) begin
      exp_r.push_back(mq[0]);
      exp_f.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (wa) mq.push_back(wr_data);
    if (wr_en && !wa) m_ovf = 1;
    else if (clr_err) m_ovf = 0;
    if (rd_en && !ra) m_unf = 1;
    else if (clr_err) m_unf = 0;
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    chk("count_reg",  32'(r_count), 32'(n));
    chk("count_fwft", 32'(f_count), 32'(n));
    chk("full",       {30'd0, r_full,  f_full},  {30'd0, n == DEPTH, n == DEPTH});
    chk("empty",      {30'd0, r_empty, f_empty}, {30'd0, n == 0, n == 0});
    chk("almost_full",  {30'd0, r_af, f_af}, {30'd0, n >= DEPTH - 2, n >= DEPTH - 2});
    chk("almost_empty", {30'd0, r_ae, f_ae}, {30'd0, n <= 2, n <= 2});
    chk("overflow",   {30'd0, r_ovf, f_ovf}, {30'd0, m_ovf, m_ovf});
    chk("underflow",  {30'd0, r_unf, f_unf}, {30'd0, m_unf, m_unf});
    chk("fwft_valid", 32'(f_valid), 32'(n > 0));
    if (n > 0) chk("fwft_head", 32'(f_data), 32'(mq[0]));
  endtask

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit c = 1'b0, input bit rs = 1'b0);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c; rst = rs;
    model_edge();
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Monitors: registered mode delivers on rd_valid; FWFT delivers when a valid head is consumed.
  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      if (exp_r.size() == 0) chk("reg_spurious_valid", 32'd1, 32'd0);
      else                   chk("reg_rd_data", 32'(r_data), 32'(exp_r.pop_front()));
    end
    if (f_valid === 1'b1 && rd_en === 1'b1 && rst === 1'b0) begin
      if (exp_f.size() == 0) chk("fwft_spurious_pop", 32'd1, 32'd0);
      else                   chk("fwft_rd_data", 32'(f_data), 32'(exp_f.pop_front()));
    end
  end

  initial begin
    logic [DW-1:0] d;
    bit w, r, c, rs;
    int pw, pr;

    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("reset_rd_data", 32'(r_data), 32'h0);
    chk("reset_rd_valid", {30'd0, r_valid, f_valid}, 32'h0);

    // Registered read of a single word, then FWFT fall-through.
    cyc(1, 8'hA5, 0);
    chk("fwft_fallthrough_a5", {23'd0, f_valid, f_data}, {23'd0, 1'b1, 8'hA5});
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    chk("reg_read_a5", {23'd0, r_valid, r_data}, {23'd0, 1'b1, 8'hA5});
    chk("empty_after_a5", 32'(r_empty), 32'd1);
    cyc(0, 8'h00, 0);
    chk("reg_valid_one_cycle", 32'(r_valid), 32'd0);

    // Fill to full, overflow on the 17th write, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, DW'(i), 0);
      if (i == 12) chk("af_low_at_13", 32'(r_af), 32'd0);
      if (i == 13) chk("af_high_at_14", 32'(r_af), 32'd1);
    end
    chk("full_at_16", {27'd0, r_full, r_count}, {27'd0, 1'b1, 5'd16});
    cyc(1, 8'hFF, 0);
    chk("overflow_17th", 32'(r_ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0, 1);
    chk("ovf_cleared", 32'(r_ovf), 32'd0);

    // Simultaneous read and write while full.
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'($urandom_range(0, 255)), 0);
    cyc(1, 8'h55, 1);
    chk("full_rw_count", 32'(r_count), 32'd16);
    chk("full_rw_no_ovf", 32'(r_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1);
    chk("last_word_55", 32'(r_data), 32'h55);

    // Underflow, set-wins-over-clear, then clear.
    cyc(0, 8'h00, 1);
    chk("underflow_set", {30'd0, r_unf, r_valid}, {30'd0, 1'b1, 1'b0});
    cyc(0, 8'h00, 1, 1);
    chk("underflow_set_wins", 32'(r_unf), 32'd1);
    cyc(0, 8'h00, 0, 1);
    chk("underflow_cleared", 32'(r_unf), 32'd0);

    cyc(1, 8'h3C, 0);
    chk("fwft_3c", {23'd0, f_valid, f_data}, {23'd0, 1'b1, 8'h3C});
    cyc(0, 8'h00, 1);
    chk("fwft_empty_after_rd", 32'(f_empty), 32'd1);

    // Wrap the pointers, fill to 9, reset with requests pending.
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, DW'(8'h80 + i), 0);
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1);
    for (int i = 0; i < 9; i++)  cyc(1, DW'(8'h90 + i), 0);
    cyc(0, 8'h00, 0);
    cyc(1, 8'hAA, 1, 0, 1);
    chk("rst_count", 32'(r_count), 32'd0);
    chk("rst_outputs", {29'd0, r_valid, r_data == 8'h00, r_empty}, {29'd0, 1'b0, 1'b1, 1'b1});
    cyc(1, 8'h7E, 0);
    cyc(0, 8'h00, 1);
    chk("post_rst_7e", 32'(r_data), 32'h7E);

    // Randomised phases alternating fill, drain and mixed traffic.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 150) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 25; pr = 80; end
        default: begin pw = 55; pr = 55; end
      endcase
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < pr);
      c  = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 399) == 0);
      d  = DW'($urandom_range(0, 255));
      cyc(w, d, r, c, rs);
    end

    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    chk("scoreboard_drained", 32'(exp_r.size() + exp_f.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
